fp_addsub_pipe: RTL
===================

Name: fp_addsub_pipe

Overview:
- Parametrised, 3-stage pipelined IEEE-754 add/subtract unit for the floating-point coprocessor. It is the successor to the single-cycle combinational adder.
- Adds a subtract mode, round-to-nearest-even, special-value handling, exception flags and a valid/ready handshake on both sides.
- Sits between the coprocessor register read and the FP writeback.
- Default configuration is single precision.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, stored mantissa (fraction) width. Total word width W = 1+EXP_W+MAN_W.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands and op valid
- in_ready  out  1  unit accepts input this cycle
- op  in  1  0 = a+b, 1 = a-b
- a  in  W  operand A
- b  in  W  operand B
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  W  rounded result
- flags  out  4  {invalid, overflow, underflow, inexact}

Behaviour:
- Reset (async, reset_n=0): all stage valid bits 0, out_valid=0, result=0, flags=0. Reset mid-operation discards all in-flight operations; the first result after release requires a new input.
- Stall rule:
  - advance = !out_valid || out_ready; in_ready = advance.
  - All three stages shift together when advance=1 and hold when advance=0.
  - A transfer occurs when in_valid && in_ready.
  - Bubbles propagate as invalid stages and are not collapsed.
  - Latency is exactly 3 cycles from the accept edge to out_valid=1 when unstalled. Throughput is 1 per cycle.
- result and flags are registered and hold stable while out_valid && !out_ready.
- Stage 1 (unpack/align):
  - Effective sign of b is b.sign ^ op.
  - Inputs with exp=0 are flushed to signed zero (no denormal support).
  - Swap so the larger magnitude is first.
  - Prepend the hidden 1 and right-shift the smaller mantissa by the exponent difference, keeping guard, round and sticky bits.
  - Differences >= MAN_W+3 reduce the smaller operand to sticky only.
- Stage 2 (add):
  - Same effective sign: add the mantissas (MAN_W+4 bit adder plus carry).
  - Opposite signs: subtract smaller from larger; result sign is the sign of the larger.
  - Equal magnitudes with opposite signs give +0.
- Stage 3 (normalise/round/pack):
  - On carry-out, shift right 1 and increment the exponent.
  - Otherwise, leading-zero count and left shift with exponent decrement.
  - Round to nearest, ties to even, using guard/round/sticky; renormalise on mantissa overflow from rounding.
- Special cases, resolved in stage 1 and carried as a tag:
  - Any NaN input -> canonical quiet NaN: sign 0, exp all 1, fraction MSB 1, rest 0.
  - inf + (-inf) (after op) -> canonical NaN with invalid=1.
  - inf with a finite operand -> that inf.
  - Zero plus x -> x, with the x input flushed if it is denormal.
  - (-0)+(-0) -> -0.
- Overflow: biased exponent >= 2^EXP_W-1 after rounding -> signed inf, overflow=1, inexact=1.
- Underflow: normalised exponent <= 0 -> signed zero, underflow=1, inexact=1.
- inexact = 1 whenever any discarded bit (guard/round/sticky) was nonzero.
- flags are per-result, not sticky.

Test Plan:
- Unstalled add:
  - a=42C80000, b=41C80000, op=0, out_ready=1 -> result 42FA0000, flags 0, out_valid exactly 3 cycles after accept.
  - a=C1B80000, b=C5AF3800, op=0 -> C5AFF000.
  - a=00FFFFFF, b=00FFFFFF -> 017FFFFF.
- Subtract and ties: 3F800000 - 3F800000 -> 00000000, flags 0. 3F800000 + 33800000 -> 3F800000 (tie to even), inexact=1.
- Specials:
  - 7F7FFFFF + 7F7FFFFF -> 7F800000 with overflow=1, inexact=1.
  - 7F800000 - 7F800000 -> 7FC00000 with invalid=1.
  - 7FC00001 + 3F800000 -> 7FC00000.
- Backpressure: stream 5 back-to-back ops with out_ready held low for 2 cycles mid-stream -> in_ready low exactly during the stall, result and flags stable, all 5 results delivered in order with no loss or duplication.
- Reset mid-operation: assert reset_n=0 asynchronously with 3 ops in flight -> out_valid falls immediately with no clock edge, and no stale result appears after release.
- EXP_W=11, MAN_W=52 instance: 3FF0000000000000 + 3FF0000000000000 -> 4000000000000000 after 3 cycles.

Source files
------------

// File: rtl/fp_addsub_pipe.sv
// ============================================================================
// Module      : fp_addsub_pipe
// Description : 3-stage pipelined IEEE-754 add/subtract, round-to-nearest-even,
//               flush-to-zero, valid/ready handshake on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_addsub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   op,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic [3:0]             flags
);

    localparam int c_w     = 1 + EXP_W + MAN_W;
    localparam int c_mw    = MAN_W + 4;           // hidden + fraction + guard/round/sticky
    localparam int c_ew    = EXP_W + 2;           // signed working exponent
    localparam int c_lzw   = $clog2(c_mw + 1);
    localparam int c_emax  = (1 << EXP_W) - 1;
    localparam logic [c_w-1:0] c_qnan = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    logic w_advance;
    assign w_advance = !out_valid || out_ready;
    assign in_ready  = w_advance;

    // ---------------- stage 1: unpack / classify / align ----------------
    logic             w_sa, w_sb, w_a_big, w_spec;
    logic [EXP_W-1:0] w_ea, w_eb, w_el, w_es, w_diff;
    logic [MAN_W-1:0] w_fa, w_fb, w_fl, w_fs;
    logic             w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero, w_sl;
    logic [c_mw-1:0]  w_ext, w_ms;
    logic [2*c_mw-1:0] w_wide;
    logic [c_w-1:0]   w_spec_res;
    logic [3:0]       w_spec_flags;

    always_comb begin
        w_sa     = a[c_w-1];
        w_sb     = b[c_w-1] ^ op;
        w_ea     = a[c_w-2:MAN_W];
        w_eb     = b[c_w-2:MAN_W];
        w_fa     = a[MAN_W-1:0];
        w_fb     = b[MAN_W-1:0];
        w_a_nan  = (&w_ea) && (|w_fa);
        w_b_nan  = (&w_eb) && (|w_fb);
        w_a_inf  = (&w_ea) && !(|w_fa);
        w_b_inf  = (&w_eb) && !(|w_fb);
        w_a_zero = !(|w_ea);
        w_b_zero = !(|w_eb);

        w_a_big  = {w_ea, w_fa} >= {w_eb, w_fb};
        w_sl     = w_a_big ? w_sa : w_sb;
        w_el     = w_a_big ? w_ea : w_eb;
        w_fl     = w_a_big ? w_fa : w_fb;
        w_es     = w_a_big ? w_eb : w_ea;
        w_fs     = w_a_big ? w_fb : w_fa;
        w_diff   = w_el - w_es;

        // The lower half of the widened shift holds every bit pushed out; it folds into sticky.
        w_ext    = {1'b1, w_fs, 3'b000};
        w_wide   = {w_ext, {c_mw{1'b0}}} >> w_diff;
        if (w_diff >= EXP_W'(MAN_W + 3))
            w_ms = c_mw'(1);
        else
            w_ms = w_wide[2*c_mw-1:c_mw] | {{(c_mw-1){1'b0}}, |w_wide[c_mw-1:0]};
    end

    always_comb begin
        w_spec       = 1'b1;
        w_spec_res   = '0;
        w_spec_flags = 4'b0000;
        if (w_a_nan || w_b_nan) begin
            w_spec_res = c_qnan;
        end else if (w_a_inf && w_b_inf && (w_sa != w_sb)) begin
            w_spec_res   = c_qnan;
            w_spec_flags = 4'b1000;
        end else if (w_a_inf) begin
            w_spec_res = {w_sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (w_b_inf) begin
            w_spec_res = {w_sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (w_a_zero && w_b_zero) begin
            w_spec_res = {w_sa & w_sb, {(c_w-1){1'b0}}};
        end else if (w_a_zero) begin
            w_spec_res = {w_sb, b[c_w-2:0]};
        end else if (w_b_zero) begin
            w_spec_res = a;
        end else begin
            w_spec = 1'b0;
        end
    end

    logic             r_v1, r_sign1, r_sub1, r_spec1;
    logic [EXP_W-1:0] r_exp1;
    logic [c_mw-1:0]  r_ml1, r_ms1;
    logic [c_w-1:0]   r_sres1;
    logic [3:0]       r_sflg1;

    // ---------------- stage 2: add / subtract ----------------
    logic [c_mw:0] w_sum;
    assign w_sum = r_sub1 ? ({1'b0, r_ml1} - {1'b0, r_ms1})
                          : ({1'b0, r_ml1} + {1'b0, r_ms1});

    logic             r_v2, r_sign2, r_spec2;
    logic [EXP_W-1:0] r_exp2;
    logic [c_mw:0]    r_sum2;
    logic [c_w-1:0]   r_sres2;
    logic [3:0]       r_sflg2;

    // ---------------- stage 3: normalise / round / pack ----------------
    logic [c_lzw-1:0]       w_lz;
    logic [c_mw-1:0]        w_norm;
    logic signed [c_ew-1:0] w_expn, w_expf;
    logic                   w_rup, w_inexact;
    logic [MAN_W+1:0]       w_mr;
    logic [MAN_W-1:0]       w_frac;
    logic [c_w-1:0]         w_res;
    logic [3:0]             w_flg;

    // Last hit wins, so w_lz ends up relative to the highest set bit.
    always_comb begin
        w_lz = c_lzw'(c_mw);
        for (int i = 0; i < c_mw; i++)
            if (r_sum2[i]) w_lz = c_lzw'(c_mw - 1 - i);
    end

    always_comb begin
        if (r_sum2[c_mw]) begin
            w_norm = {r_sum2[c_mw:2], r_sum2[1] | r_sum2[0]};
            w_expn = c_ew'(r_exp2) + c_ew'(1);
        end else begin
            w_norm = r_sum2[c_mw-1:0] << w_lz;
            w_expn = c_ew'(r_exp2) - c_ew'(w_lz);
        end
        w_inexact = |w_norm[2:0];
        w_rup     = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
        w_mr      = {1'b0, w_norm[c_mw-1:3]} + (MAN_W+2)'(w_rup);
        w_expf    = w_expn + c_ew'(w_mr[MAN_W+1]);
        w_frac    = w_mr[MAN_W+1] ? w_mr[MAN_W:1] : w_mr[MAN_W-1:0];

        w_res = {r_sign2, w_expf[EXP_W-1:0], w_frac};
        w_flg = {3'b000, w_inexact};
        if (r_spec2) begin
            w_res = r_sres2;
            w_flg = r_sflg2;
        end else if (r_sum2 == '0) begin
            w_res = '0;
            w_flg = 4'b0000;
        end else if (int'(w_expn) <= 0) begin
            w_res = {r_sign2, {(c_w-1){1'b0}}};
            w_flg = 4'b0011;
        end else if (int'(w_expf) >= c_emax) begin
            w_res = {r_sign2, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_flg = 4'b0101;
        end
    end

    // ---------------- pipeline registers ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_v1      <= 1'b0;
            r_sign1   <= 1'b0;
            r_sub1    <= 1'b0;
            r_spec1   <= 1'b0;
            r_exp1    <= '0;
            r_ml1     <= '0;
            r_ms1     <= '0;
            r_sres1   <= '0;
            r_sflg1   <= '0;
            r_v2      <= 1'b0;
            r_sign2   <= 1'b0;
            r_spec2   <= 1'b0;
            r_exp2    <= '0;
            r_sum2    <= '0;
            r_sres2   <= '0;
            r_sflg2   <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
        end else if (w_advance) begin
            r_v1      <= in_valid;
            r_sign1   <= w_sl;
            r_sub1    <= w_sa ^ w_sb;
            r_spec1   <= w_spec;
            r_exp1    <= w_el;
            r_ml1     <= {1'b1, w_fl, 3'b000};
            r_ms1     <= w_ms;
            r_sres1   <= w_spec_res;
            r_sflg1   <= w_spec_flags;
            r_v2      <= r_v1;
            r_sign2   <= r_sign1;
            r_spec2   <= r_spec1;
            r_exp2    <= r_exp1;
            r_sum2    <= w_sum;
            r_sres2   <= r_sres1;
            r_sflg2   <= r_sflg1;
            out_valid <= r_v2;
            result    <= w_res;
            flags     <= w_flg;
        end
    end

endmodule

`default_nettype wire
